// File: rtl/seg_scan_pkg.sv
// Shared constants for the seg_scan display multiplexer.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for the decimal digits 0..9
//   - SEG_DASH (shown for BCD values 10..15) and SEG_OFF (all segments dark)
//   - Active-low one-hot digit selects for the four slots, plus DIG_OFF
//   - slot_e: the scan slot index, in scan order
package seg_scan_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] DIG_SEL_MIN1   = 4'b1110;
  localparam logic [3:0] DIG_SEL_MIN10  = 4'b1101;
  localparam logic [3:0] DIG_SEL_HOUR1  = 4'b1011;
  localparam logic [3:0] DIG_SEL_HOUR10 = 4'b0111;
  localparam logic [3:0] DIG_OFF        = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_MIN1   = 2'd0,
    SLOT_MIN10  = 2'd1,
    SLOT_HOUR1  = 2'd2,
    SLOT_HOUR10 = 2'd3
  } slot_e;

endpackage

// File: rtl/seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd  in  4  digit value; 10..15 are not decimal digits and show a dash
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment clock display driver (HH:MM).
// A prescaler divides clk into digit slots of SCAN_DIV cycles; the slot index
// walks min1, min_10, hour1, hour_10. The first cycle of every slot is dark
// (dead time) so the previous digit's segments never ghost onto the next one.
// Inputs are captured into shadow registers once per frame so a frame never
// mixes old and new digits. The colon (dp, shown in the hour1 slot) toggles
// every BLINK_FRAMES frames.
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  asynchronous active-low reset
//   hour_10   in  4  BCD tens of hours
//   hour1     in  4  BCD units of hours
//   min_10    in  4  BCD tens of minutes
//   min1      in  4  BCD units of minutes
//   lz_blank  in  1  blank a leading zero in hour_10
//   dig       out 4  active-low one-hot digit select (bit0 = min1 .. bit3 = hour_10)
//   seg       out 7  active-low segments {g,f,e,d,c,b,a}
//   dp        out 1  active-low colon
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_10,
  input  logic [3:0] hour1,
  input  logic [3:0] min_10,
  input  logic [3:0] min1,
  input  logic       lz_blank,
  output logic [3:0] dig,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  // A one-frame blink period still needs a 1-bit counter to keep widths legal.
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre;
  slot_e         idx;
  logic [FW-1:0] frame_cnt;
  logic          colon;
  logic [3:0]    sh_min1;
  logic [3:0]    sh_min10;
  logic [3:0]    sh_hour1;
  logic [3:0]    sh_hour10;

  logic          tick;
  logic          frame_end;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [3:0]    next_dig;
  logic [6:0]    next_seg;
  logic          next_dp;

  assign tick      = (pre == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == SLOT_HOUR10);

  // Pick the shadow digit and digit select for the slot being shown.
  always_comb begin
    cur_digit = sh_min1;
    next_dig  = DIG_SEL_MIN1;
    case (idx)
      SLOT_MIN1: begin
        cur_digit = sh_min1;
        next_dig  = DIG_SEL_MIN1;
      end
      SLOT_MIN10: begin
        cur_digit = sh_min10;
        next_dig  = DIG_SEL_MIN10;
      end
      SLOT_HOUR1: begin
        cur_digit = sh_hour1;
        next_dig  = DIG_SEL_HOUR1;
      end
      SLOT_HOUR10: begin
        cur_digit = sh_hour10;
        next_dig  = DIG_SEL_HOUR10;
      end
      default: begin
        cur_digit = sh_min1;
        next_dig  = DIG_SEL_MIN1;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Leading-zero blanking darkens the segments but keeps the digit selected,
  // so slot timing and brightness of the other digits are unchanged.
  always_comb begin
    next_seg = cur_seg;
    if ((idx == SLOT_HOUR10) && lz_blank && (sh_hour10 == 4'd0)) begin
      next_seg = SEG_OFF;
    end
    next_dp = (idx == SLOT_HOUR1) ? ~colon : 1'b1;
  end

  // Prescaler, slot index, frame snapshot and colon blink.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre       <= '0;
      idx       <= SLOT_MIN1;
      frame_cnt <= '0;
      colon     <= 1'b0;
      sh_min1   <= 4'd0;
      sh_min10  <= 4'd0;
      sh_hour1  <= 4'd0;
      sh_hour10 <= 4'd0;
    end else begin
      if (tick) begin
        pre <= '0;
        idx <= slot_e'(idx + 2'd1);
      end else begin
        pre <= pre + 1'b1;
      end

      if (frame_end) begin
        sh_min1   <= min1;
        sh_min10  <= min_10;
        sh_hour1  <= hour1;
        sh_hour10 <= hour_10;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          colon     <= ~colon;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Registered outputs: dark on the slot-change edge, otherwise the current slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig <= DIG_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (tick) begin
      dig <= DIG_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      dig <= next_dig;
      seg <= next_seg;
      dp  <= next_dp;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// The reference model derives every output from the edge number since reset
// release: slot = ((n-1)/D) mod 4, dead when the prescaler would wrap, colon
// from the number of completed frames. The driver pushes the expected
// {dig,seg,dp} for the coming edge; the monitor pops and compares after it.
module tb_seg_scan;

  localparam int D  = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hour_10;
  logic [3:0] hour1;
  logic [3:0] min_10;
  logic [3:0] min1;
  logic       lz_blank;
  logic [3:0] dig;
  logic [6:0] seg;
  logic       dp;

  seg_scan #(
    .SCAN_DIV     (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hour_10  (hour_10),
    .hour1    (hour1),
    .min_10   (min_10),
    .min1     (min1),
    .lz_blank (lz_blank),
    .dig      (dig),
    .seg      (seg),
    .dp       (dp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  bit          running = 1'b0;
  int          n       = 0;      // edges since reset release
  logic [3:0]  snap[4];          // digits captured at the last frame boundary
  logic [6:0]  seg_tab[16];
  logic [11:0] mon_exp;

  function automatic logic [11:0] model(input int e);
    int         slot;
    int         colon_v;
    logic [3:0] dig_v;
    logic [6:0] seg_v;
    logic       dp_v;
    if (((e - 1) % D) == D - 1) return {4'b1111, 7'b1111111, 1'b1};
    slot    = ((e - 1) / D) % 4;
    colon_v = (((e - 1) / (4 * D)) / BF) % 2;
    dig_v   = ~(4'b0001 << slot);
    if (slot == 3 && lz_blank && snap[3] == 4'd0) seg_v = 7'b1111111;
    else seg_v = seg_tab[snap[slot]];
    dp_v = (slot == 2) ? ~colon_v[0] : 1'b1;
    return {dig_v, seg_v, dp_v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_edge();
    n = n + 1;
    exp_q.push_back(model(n));
    if (n % (4 * D) == 0) begin
      snap[0] = min1;
      snap[1] = min_10;
      snap[2] = hour1;
      snap[3] = hour_10;
    end
  endtask

  task automatic step(input bit rnd, input int chance);
    @(negedge clk);
    if (rnd && $urandom_range(99) < chance) begin
      hour_10  = 4'($urandom_range(15));
      hour1    = 4'($urandom_range(15));
      min_10   = 4'($urandom_range(15));
      min1     = 4'($urandom_range(15));
      lz_blank = 1'($urandom_range(1));
    end
    push_edge();
  endtask

  task automatic run(input int cycles, input bit rnd, input int chance);
    for (int i = 0; i < cycles; i++) step(rnd, chance);
  endtask

  task automatic clear_snap();
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
  endtask

  task automatic check_reset(input string name);
    n_cmp++;
    if ({dig, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      n_bad++;
      $display("FAIL %s: got dig=%b seg=%b dp=%b, expected dig=1111 seg=1111111 dp=1",
               name, dig, seg, dp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (running) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scan_underflow: got no expected entry at time %0t, expected one queued", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({dig, seg, dp} !== mon_exp) begin
          n_bad++;
          $display("FAIL scan t=%0t: got dig=%b seg=%b dp=%b, expected dig=%b seg=%b dp=%b",
                   $time, dig, seg, dp, mon_exp[11:8], mon_exp[7:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    seg_tab[0] = 7'b1000000;  seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100;  seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001;  seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010;  seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000;  seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    clear_snap();

    hour_10 = 4'd1; hour1 = 4'd2; min_10 = 4'd5; min1 = 4'd9; lz_blank = 1'b0;

    // Reset held: outputs dark.
    repeat (3) @(negedge clk);
    check_reset("reset_hold");

    // Release; first edge shows min1 slot with zero shadow.
    @(negedge clk);
    rst     = 1'b1;
    running = 1'b1;
    n       = 0;
    clear_snap();
    push_edge();

    // Snapshot 12:59 appears in the second frame.
    run(3 * 4 * D, 1'b0, 0);

    // Change min1 mid-frame during slot 1; must wait for the next boundary.
    for (int i = 0; i < 4 * D; i++) begin
      step(1'b0, 0);
      if ((n / D) % 4 == 1) break;
    end
    min1 = 4'd3;
    run(3 * 4 * D, 1'b0, 0);

    // Invalid digit and leading-zero blanking, then blanking disabled.
    min_10 = 4'hA; hour_10 = 4'd0; lz_blank = 1'b1;
    run(2 * 4 * D, 1'b0, 0);
    lz_blank = 1'b0;
    run(2 * 4 * D, 1'b0, 0);

    // Randomized inputs over many frames and several colon periods.
    run(800, 1'b1, 20);

    // Asynchronous reset inside a lit hour1 slot.
    for (int i = 0; i < 4 * D * 2; i++) begin
      step(1'b0, 0);
      if (((n - 1) / D) % 4 == 2 && (n % D) != 0) break;
    end
    #2;
    rst     = 1'b0;
    running = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (2) @(negedge clk);
    check_reset("async_reset_hold");
    exp_q.delete();

    // Restart: scan begins again at slot 0 with zero shadow.
    rst     = 1'b1;
    running = 1'b1;
    n       = 0;
    clear_snap();
    push_edge();
    run(4 * 4 * D, 1'b1, 10);

    @(posedge clk);
    #2;
    running = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
